// File: rtl/game_controller_if.sv
// Signal bundle between the game sequencer and its neighbours: frame timing,
// collision detection and player input in; game status and respawn out.
interface game_controller_if;
  logic       frame_start;
  logic       start;
  logic       collision;
  logic [8:0] y;
  logic [1:0] gameState;
  logic [1:0] lives;
  logic [3:0] level;
  logic [7:0] time_left;
  logic       respawn;

  modport master (
    output frame_start, start, collision, y,
    input  gameState, lives, level, time_left, respawn
  );

  modport slave (
    input  frame_start, start, collision, y,
    output gameState, lives, level, time_left, respawn
  );
endinterface

// File: rtl/game_controller.sv
// Crossing-game sequencer: owns the IDLE/PLAY/WIN/LOSE state, lives, level,
// the per-attempt countdown and the one-cycle respawn pulse.
module game_controller #(
  parameter int MAX_LIVES      = 3,
  parameter int NUM_LEVELS     = 4,
  parameter int TIME_LIMIT     = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int GOAL_Y         = 20
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  game_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int INV_W   = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [3:0]         LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [7:0]         TIME_INIT  = 8'(TIME_LIMIT);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [INV_W-1:0]   INV_INIT   = INV_W'(INVULN_FRAMES);
  localparam logic [8:0]         GOAL_ROW   = 9'(GOAL_Y);

  state_t             state_reg,      state_next;
  logic [1:0]         lives_reg,      lives_next;
  logic [3:0]         level_reg,      level_next;
  logic [7:0]         time_reg,       time_next;
  logic [FRAME_W-1:0] frame_reg,      frame_next;
  logic [INV_W-1:0]   invuln_reg,     invuln_next;
  logic               respawn_reg,    respawn_next;
  logic               start_prev_reg;

  logic start_rise;
  logic goal_hit;
  logic hazard_hit;
  logic timeout;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg      <= IDLE;
      lives_reg      <= LIVES_INIT;
      level_reg      <= '0;
      time_reg       <= TIME_INIT;
      frame_reg      <= '0;
      invuln_reg     <= '0;
      respawn_reg    <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      level_reg      <= level_next;
      time_reg       <= time_next;
      frame_reg      <= frame_next;
      invuln_reg     <= invuln_next;
      respawn_reg    <= respawn_next;
      start_prev_reg <= bus.start;
    end
  end

  // y still shows the pre-respawn position while respawn is high, so goal and
  // hazard checks are masked for that cycle; the timeout is not.
  assign start_rise = bus.start & ~start_prev_reg;
  assign goal_hit   = ~respawn_reg & (bus.y <= GOAL_ROW);
  assign hazard_hit = ~respawn_reg & bus.collision & (invuln_reg == '0);
  assign timeout    = (time_reg == '0);

  always_comb begin
    state_next   = state_reg;
    lives_next   = lives_reg;
    level_next   = level_reg;
    time_next    = time_reg;
    frame_next   = frame_reg;
    invuln_next  = invuln_reg;
    respawn_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_rise) begin
          state_next   = PLAY;
          lives_next   = LIVES_INIT;
          level_next   = '0;
          time_next    = TIME_INIT;
          frame_next   = '0;
          invuln_next  = '0;
          respawn_next = 1'b1;
        end
      end
      PLAY: begin
        if (goal_hit) begin
          if (level_reg == LAST_LEVEL) begin
            state_next = WIN;
          end else begin
            level_next   = level_reg + 4'd1;
            time_next    = TIME_INIT;
            frame_next   = '0;
            respawn_next = 1'b1;
          end
        end else if (hazard_hit || timeout) begin
          if (lives_reg == 2'd1) begin
            lives_next = 2'd0;
            state_next = LOSE;
          end else begin
            lives_next   = lives_reg - 2'd1;
            time_next    = TIME_INIT;
            frame_next   = '0;
            invuln_next  = INV_INIT;
            respawn_next = 1'b1;
          end
        end else if (bus.frame_start) begin
          if (invuln_reg != '0) invuln_next = invuln_reg - INV_W'(1);
          if (frame_reg == FRAME_LAST) begin
            frame_next = '0;
            if (time_reg != '0) time_next = time_reg - 8'd1;
          end else begin
            frame_next = frame_reg + FRAME_W'(1);
          end
        end
      end
      default: begin
        if (start_rise) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.gameState = state_reg;
    bus.lives     = lives_reg;
    bus.level     = level_reg;
    bus.time_left = time_reg;
    bus.respawn   = respawn_reg;
  end

endmodule
